// File: rtl/dds_pkg.sv
// Shared definitions for the DDS serial register-access engine.
package dds_pkg;

  localparam int unsigned INSTR_BITS = 8;
  localparam int unsigned DATA_BITS  = 32;
  localparam int unsigned RW_BIT     = 7;
  localparam int unsigned ADDR_MSB   = 4;
  localparam int unsigned FRAME_BITS = INSTR_BITS + DATA_BITS;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    HIGH,
    LOW,
    HOLD,
    UPDATE,
    DONE
  } state_t;

endpackage

// File: rtl/dds_spi_port_half_tick.sv
// Down-counter giving a one-cycle tick every DIV clk cycles; restart reloads it.
module spi_half_tick #(
  parameter int unsigned DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam logic [7:0] RELOAD = 8'(DIV - 1);

  logic [7:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= RELOAD;
    end else if (restart || cnt == '0) begin
      cnt <= RELOAD;
    end else begin
      cnt <= cnt - 8'd1;
    end
  end

  assign tick = (cnt == '0);

endmodule

// File: rtl/dds_spi_port.sv
// Serial register-access engine: shifts one 40-bit instruction+data frame to the
// DDS per wr_start, captures read data from SDO and optionally pulses IO_UPDATE.
module dds_spi_port
  import dds_pkg::*;
#(
  parameter int unsigned CLK_DIV     = 2,
  parameter int unsigned IOUP_WIDTH  = 4,
  parameter bit          AUTO_UPDATE = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_start,
  input  logic [7:0]  wr_addr,
  input  logic [31:0] wr_data,
  output logic        wr_done,
  output logic [31:0] wr_out,
  output logic        busy,
  output logic        SCLK,
  output logic        CSB,
  output logic        SDIO,
  input  logic        SDO,
  output logic        IO_UPDATE
);

  state_t                 state;
  logic [FRAME_BITS-1:0]  sh_reg;
  logic [DATA_BITS-1:0]   rx;
  logic [5:0]             bit_cnt;
  logic                   is_read;
  logic                   restart;
  logic                   div_tick;
  logic                   upd_tick;

  spi_half_tick #(.DIV(CLK_DIV)) u_div (
    .clk     (clk),
    .rst     (rst),
    .restart (restart),
    .tick    (div_tick)
  );

  spi_half_tick #(.DIV(IOUP_WIDTH)) u_upd (
    .clk     (clk),
    .rst     (rst),
    .restart (restart),
    .tick    (upd_tick)
  );

  // Both counters reload on every state change so each state starts a fresh period.
  always_comb begin
    restart = 1'b0;
    case (state)
      IDLE:                   restart = wr_start;
      SETUP, HIGH, LOW, HOLD: restart = div_tick;
      UPDATE:                 restart = upd_tick;
      DONE:                   restart = 1'b1;
      default:                restart = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      sh_reg    <= '0;
      rx        <= '0;
      bit_cnt   <= '0;
      is_read   <= 1'b0;
      wr_done   <= 1'b0;
      wr_out    <= '0;
      busy      <= 1'b0;
      SCLK      <= 1'b0;
      CSB       <= 1'b1;
      SDIO      <= 1'b0;
      IO_UPDATE <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (wr_start) begin
            sh_reg  <= {wr_addr, wr_data};
            is_read <= wr_addr[RW_BIT];
            bit_cnt <= 6'(FRAME_BITS - 1);
            busy    <= 1'b1;
            CSB     <= 1'b0;
            SDIO    <= wr_addr[INSTR_BITS-1];
            state   <= SETUP;
          end
        end
        SETUP: begin
          if (div_tick) begin
            SCLK  <= 1'b1;
            state <= HIGH;
          end
        end
        HIGH: begin
          if (div_tick) begin
            SCLK <= 1'b0;
            if (is_read && bit_cnt < 6'(DATA_BITS)) begin
              rx <= {rx[DATA_BITS-2:0], SDO};
            end
            sh_reg <= sh_reg << 1;
            SDIO   <= sh_reg[FRAME_BITS-2];
            state  <= LOW;
          end
        end
        LOW: begin
          if (div_tick) begin
            if (bit_cnt == '0) begin
              state <= HOLD;
            end else begin
              bit_cnt <= bit_cnt - 6'd1;
              SCLK    <= 1'b1;
              state   <= HIGH;
            end
          end
        end
        HOLD: begin
          if (div_tick) begin
            CSB  <= 1'b1;
            SDIO <= 1'b0;
            if (!is_read && AUTO_UPDATE) begin
              IO_UPDATE <= 1'b1;
              state     <= UPDATE;
            end else begin
              wr_done <= 1'b1;
              if (is_read) begin
                wr_out <= rx;
              end
              state <= DONE;
            end
          end
        end
        UPDATE: begin
          if (upd_tick) begin
            IO_UPDATE <= 1'b0;
            wr_done   <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          wr_done <= 1'b0;
          busy    <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dds_spi_port.sv
// Self-checking bench for dds_spi_port: three parameterisations, a bus-level DDS
// model that captures SDIO / drives SDO, and a transaction-level reference model.
module tb_dds_spi_port;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic [2:0]  start_v = '0;
  logic [2:0]  sdo_v   = '0;
  logic [2:0]  done_v, busy_v, sclk_v, csb_v, sdio_v, ioup_v;
  logic [31:0] out_v [3];

  int errors = 0;
  int checks = 0;

  int div_of [3] = '{2, 1, 2};
  int w_of   [3] = '{4, 3, 4};
  bit au_of  [3] = '{1'b1, 1'b1, 1'b0};

  logic [31:0] exp_out [3] = '{32'h0, 32'h0, 32'h0};

  always #5 clk = ~clk;

  dds_spi_port #(.CLK_DIV(2), .IOUP_WIDTH(4), .AUTO_UPDATE(1'b1)) dut0 (
    .clk(clk), .rst(rst), .wr_start(start_v[0]), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_done(done_v[0]), .wr_out(out_v[0]), .busy(busy_v[0]), .SCLK(sclk_v[0]),
    .CSB(csb_v[0]), .SDIO(sdio_v[0]), .SDO(sdo_v[0]), .IO_UPDATE(ioup_v[0]));

  dds_spi_port #(.CLK_DIV(1), .IOUP_WIDTH(3), .AUTO_UPDATE(1'b1)) dut1 (
    .clk(clk), .rst(rst), .wr_start(start_v[1]), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_done(done_v[1]), .wr_out(out_v[1]), .busy(busy_v[1]), .SCLK(sclk_v[1]),
    .CSB(csb_v[1]), .SDIO(sdio_v[1]), .SDO(sdo_v[1]), .IO_UPDATE(ioup_v[1]));

  dds_spi_port #(.CLK_DIV(2), .IOUP_WIDTH(4), .AUTO_UPDATE(1'b0)) dut2 (
    .clk(clk), .rst(rst), .wr_start(start_v[2]), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_done(done_v[2]), .wr_out(out_v[2]), .busy(busy_v[2]), .SCLK(sclk_v[2]),
    .CSB(csb_v[2]), .SDIO(sdio_v[2]), .SDO(sdo_v[2]), .IO_UPDATE(ioup_v[2]));

  // Frame = setup half-period + 40 full SCLK periods + hold half-period, plus the
  // IO_UPDATE pulse for writes when auto-update is on.
  function automatic int exp_lat(input int s, input bit rd);
    int t;
    t = div_of[s] * (1 + 2 * 40 + 1);
    if (!rd && au_of[s]) t += w_of[s];
    return t;
  endfunction

  // DDS bus model: records SDIO on each SCLK rise and presents read data on SDO.
  int          rises     [3] = '{0, 0, 0};
  int          csb_falls [3] = '{0, 0, 0};
  int          dones     [3] = '{0, 0, 0};
  logic [39:0] cap       [3] = '{40'h0, 40'h0, 40'h0};
  logic [31:0] pat       [3] = '{32'h0, 32'h0, 32'h0};
  logic [2:0]  prev_sclk = '0;
  logic [2:0]  prev_csb  = '1;

  always @(posedge clk) begin
    #1;
    for (int g = 0; g < 3; g++) begin
      if (!csb_v[g] && prev_csb[g]) begin
        rises[g] = 0;
        cap[g]   = '0;
        csb_falls[g]++;
      end
      if (!csb_v[g] && sclk_v[g] && !prev_sclk[g]) begin
        rises[g]++;
        cap[g] = {cap[g][38:0], sdio_v[g]};
        if (rises[g] > 8 && rises[g] <= 40) sdo_v[g] = pat[g][40 - rises[g]];
      end
      if (done_v[g]) dones[g]++;
      prev_sclk[g] = sclk_v[g];
      prev_csb[g]  = csb_v[g];
    end
  end

  // Drives one request and measures it; nbad collects protocol violations seen
  // while waiting (busy dropping, IO_UPDATE with CSB low, wr_out moving early).
  task automatic run_txn(input int s, input logic [7:0] a, input logic [31:0] d,
                         input logic [31:0] p, output int lat, output logic [39:0] word,
                         output int nrise, output int nioup, output int nbad,
                         output logic [31:0] out_at_done);
    logic [31:0] out_before;
    lat = -1; nioup = 0; nbad = 0;
    @(negedge clk);
    if (done_v[s] || busy_v[s]) nbad++;
    out_before = out_v[s];
    pat[s] = p; wr_addr = a; wr_data = d; start_v[s] = 1'b1;
    @(posedge clk);
    #1 start_v[s] = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (ioup_v[s]) begin
        nioup++;
        if (!csb_v[s]) nbad++;
      end
      if (!busy_v[s]) nbad++;
      if (done_v[s]) begin
        lat = i;
        break;
      end
      if (out_v[s] !== out_before) nbad++;
    end
    word = cap[s]; nrise = rises[s]; out_at_done = out_v[s];
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      checks++;
      if ({done_v[g], busy_v[g], sclk_v[g], csb_v[g], sdio_v[g], ioup_v[g]} !== 6'b000100
          || out_v[g] !== 32'h0) begin
        errors++;
        $display("FAIL reset_values dut%0d: done/busy/sclk/csb/sdio/ioup=%b out=%h, want 000100 out=0",
                 g, {done_v[g], busy_v[g], sclk_v[g], csb_v[g], sdio_v[g], ioup_v[g]}, out_v[g]);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_write();
    int lat, nrise, nioup, nbad;
    logic [39:0] word;
    logic [31:0] o;
    run_txn(0, 8'h01, 32'h0040_0820, $urandom, lat, word, nrise, nioup, nbad, o);
    checks++; if (word !== 40'h01_0040_0820) begin errors++; $display("FAIL write_sdio: got %h want 0100400820", word); end
    checks++; if (nrise !== 40) begin errors++; $display("FAIL write_rises: got %0d want 40", nrise); end
    checks++; if (lat !== exp_lat(0, 1'b0)) begin errors++; $display("FAIL write_latency: got %0d want %0d", lat, exp_lat(0, 1'b0)); end
    checks++; if (nioup !== w_of[0]) begin errors++; $display("FAIL write_io_update: got %0d cycles want %0d", nioup, w_of[0]); end
    checks++; if (o !== exp_out[0]) begin errors++; $display("FAIL write_wr_out: got %h want %h", o, exp_out[0]); end
    checks++; if (nbad !== 0) begin errors++; $display("FAIL write_protocol: got %0d violations want 0", nbad); end
  endtask

  task automatic test_read();
    int lat, nrise, nioup, nbad;
    logic [39:0] word;
    logic [31:0] o, d;
    d = $urandom;
    run_txn(0, 8'h8E, d, 32'hDEAD_BEEF, lat, word, nrise, nioup, nbad, o);
    exp_out[0] = 32'hDEAD_BEEF;
    checks++; if (o !== exp_out[0]) begin errors++; $display("FAIL read_wr_out: got %h want %h", o, exp_out[0]); end
    checks++; if (lat !== exp_lat(0, 1'b1)) begin errors++; $display("FAIL read_latency: got %0d want %0d", lat, exp_lat(0, 1'b1)); end
    checks++; if (nioup !== 0) begin errors++; $display("FAIL read_io_update: got %0d cycles want 0", nioup); end
    checks++; if (word !== {8'h8E, d}) begin errors++; $display("FAIL read_sdio: got %h want %h", word, {8'h8E, d}); end
    checks++; if (nbad !== 0) begin errors++; $display("FAIL read_protocol: got %0d violations want 0", nbad); end
  endtask

  task automatic test_held_start();
    int f0, d0, n_exp;
    bit settled;
    n_exp = 0;
    for (int t = 0; t < 400; t += exp_lat(0, 1'b0) + 2) n_exp++;
    @(negedge clk);
    f0 = csb_falls[0]; d0 = dones[0];
    wr_addr = 8'h02; wr_data = $urandom; start_v[0] = 1'b1;
    repeat (400) @(posedge clk);
    #1 start_v[0] = 1'b0;
    settled = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (!busy_v[0]) begin
        settled = 1'b1;
        break;
      end
    end
    repeat (5) @(negedge clk);
    checks++; if (!settled || busy_v[0]) begin errors++; $display("FAIL held_settle: busy=%b want 0", busy_v[0]); end
    checks++; if (csb_falls[0] - f0 !== n_exp) begin errors++; $display("FAIL held_accepts: got %0d want %0d", csb_falls[0] - f0, n_exp); end
    checks++; if (dones[0] - d0 !== n_exp) begin errors++; $display("FAIL held_dones: got %0d want %0d", dones[0] - d0, n_exp); end
  endtask

  task automatic test_rst_mid();
    int d0, lat, nrise, nioup, nbad;
    bit reached;
    logic [39:0] word;
    logic [31:0] o, d;
    @(negedge clk);
    pat[0] = $urandom; wr_addr = 8'h05; wr_data = $urandom; start_v[0] = 1'b1;
    @(posedge clk);
    #1 start_v[0] = 1'b0;
    reached = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (rises[0] == 20) begin
        reached = 1'b1;
        break;
      end
    end
    checks++; if (!reached) begin errors++; $display("FAIL rst_reach_bit20: rises=%0d want 20", rises[0]); end
    d0 = dones[0];
    rst = 1'b1;
    #1;
    checks++;
    if ({csb_v[0], sclk_v[0], busy_v[0], done_v[0]} !== 4'b1000) begin
      errors++;
      $display("FAIL rst_abort: csb/sclk/busy/done=%b want 1000", {csb_v[0], sclk_v[0], busy_v[0], done_v[0]});
    end
    for (int g = 0; g < 3; g++) exp_out[g] = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (200) @(negedge clk);
    checks++; if (dones[0] !== d0) begin errors++; $display("FAIL rst_no_done: got %0d pulses want 0", dones[0] - d0); end
    d = $urandom;
    run_txn(0, 8'h03, d, $urandom, lat, word, nrise, nioup, nbad, o);
    checks++;
    if (word !== {8'h03, d} || lat !== exp_lat(0, 1'b0) || nbad !== 0 || o !== exp_out[0]) begin
      errors++;
      $display("FAIL rst_recovery: word=%h lat=%0d bad=%0d out=%h want %h %0d 0 %h",
               word, lat, nbad, o, {8'h03, d}, exp_lat(0, 1'b0), exp_out[0]);
    end
  endtask

  task automatic test_back_to_back();
    int lat, nrise, nioup, nbad;
    logic [39:0] word;
    logic [31:0] o, p1, p2;
    p1 = $urandom; p2 = ~p1 ^ 32'h1234_5678;
    run_txn(1, 8'h80, $urandom, p1, lat, word, nrise, nioup, nbad, o);
    exp_out[1] = p1;
    checks++; if (o !== p1) begin errors++; $display("FAIL b2b_first_out: got %h want %h", o, p1); end
    checks++; if (lat !== exp_lat(1, 1'b1)) begin errors++; $display("FAIL b2b_first_latency: got %0d want %0d", lat, exp_lat(1, 1'b1)); end
    run_txn(1, 8'h81, $urandom, p2, lat, word, nrise, nioup, nbad, o);
    exp_out[1] = p2;
    checks++; if (nbad !== 0) begin errors++; $display("FAIL b2b_hold_first: got %0d violations want 0", nbad); end
    checks++; if (o !== p2) begin errors++; $display("FAIL b2b_second_out: got %h want %h", o, p2); end
    checks++; if (lat !== exp_lat(1, 1'b1)) begin errors++; $display("FAIL b2b_second_latency: got %0d want %0d", lat, exp_lat(1, 1'b1)); end
  endtask

  task automatic test_no_auto_update();
    int lat, nrise, nioup, nbad;
    logic [39:0] word;
    logic [31:0] o, d;
    d = $urandom;
    run_txn(2, 8'h0B, d, $urandom, lat, word, nrise, nioup, nbad, o);
    checks++; if (nioup !== 0) begin errors++; $display("FAIL noau_io_update: got %0d cycles want 0", nioup); end
    checks++; if (lat !== exp_lat(2, 1'b0)) begin errors++; $display("FAIL noau_latency: got %0d want %0d", lat, exp_lat(2, 1'b0)); end
    checks++; if (word !== {8'h0B, d}) begin errors++; $display("FAIL noau_sdio: got %h want %h", word, {8'h0B, d}); end
  endtask

  task automatic test_random();
    int s, lat, nrise, nioup, nbad, want_io;
    bit rd;
    logic [7:0]  a;
    logic [39:0] word;
    logic [31:0] o, d, p;
    for (int k = 0; k < 8; k++) begin
      s  = int'($urandom_range(0, 2));
      rd = 1'($urandom_range(0, 1));
      a  = {rd, 2'b00, 5'($urandom_range(0, 31))};
      d  = $urandom; p = $urandom;
      run_txn(s, a, d, p, lat, word, nrise, nioup, nbad, o);
      if (rd) exp_out[s] = p;
      want_io = (!rd && au_of[s]) ? w_of[s] : 0;
      checks++;
      if (lat !== exp_lat(s, rd) || word !== {a, d} || o !== exp_out[s] || nioup !== want_io
          || nrise !== 40 || nbad !== 0) begin
        errors++;
        $display("FAIL random_%0d dut%0d: lat=%0d word=%h out=%h io=%0d rises=%0d bad=%0d want %0d %h %h %0d 40 0",
                 k, s, lat, word, o, nioup, nrise, nbad, exp_lat(s, rd), {a, d}, exp_out[s], want_io);
      end
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_held_start();
    test_rst_mid();
    test_back_to_back();
    test_no_auto_update();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
